// File: rtl/aes_enc_iter.sv
// Iterative AES-128 cipher core: one full round per clock, round keys fetched
// from an external key store through rk_idx/rk, ciphertext held until taken.
module aes_enc_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] plaintext,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ciphertext
);

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t          fsm_q;
    logic [3:0]    round_q;
    logic [0:127]  state_q;
    logic [0:127]  ct_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [0:127]  round_d;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        sub_bytes = '0;
        for (int i = 0; i < 16; i++) begin
            sub_bytes[8*i +: 8] = sbox(s[8*i +: 8]);
        end
    endfunction

    // Row r of the output takes column (c+r) mod 4 of the input; bytes are column-major.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        shift_rows = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shift_rows[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
            end
        end
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        mix_columns = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            x0 = xtime(a0);
            x1 = xtime(a1);
            x2 = xtime(a2);
            x3 = xtime(a3);
            mix_columns[32*c      +: 8] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
            mix_columns[32*c + 8  +: 8] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
            mix_columns[32*c + 16 +: 8] = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
            mix_columns[32*c + 24 +: 8] = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
        end
    endfunction

    // Round NR is the final round and skips MixColumns.
    always_comb begin
        round_d = shift_rows(sub_bytes(state_q));
        if (round_q != LAST) begin
            round_d = mix_columns(round_d);
        end
        round_d = round_d ^ rk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            round_q     <= 4'd0;
            state_q     <= '0;
            ct_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= plaintext ^ rk;
                        round_q    <= 4'd1;
                        in_ready_q <= 1'b0;
                        fsm_q      <= RUN;
                    end
                end
                RUN: begin
                    state_q <= round_d;
                    if (round_q == LAST) begin
                        ct_q        <= round_d;
                        round_q     <= 4'd0;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    round_q     <= 4'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // round_q is 0 outside RUN, so it doubles as the key index.
    assign rk_idx     = round_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = ct_q;

endmodule
